uart_rx_ext: RTL and testbench
==============================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 Parameter DBIT, default 8, data bits per frame (5..9).
REQ-002 Parameter SB_TICK, default 16, oversample ticks spent in stop state (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 Parameter DIV_BITS, default 11, width of runtime baud divisor.
REQ-004 Parameter FIFO_DEPTH, default 16, receive FIFO entries, power of two, 2 or more.
REQ-005 clk  input  1  single system clock; all logic rising-edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-008 divisor  input  DIV_BITS  oversample tick period minus one, in clk cycles.
REQ-009 parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-010 rd_en  input  1  pop head FIFO entry.
REQ-011 clr_err  input  1  clear sticky overrun flag.
REQ-012 rx_data  output  DBIT  head-entry data, valid while rx_empty=0.
REQ-013 rx_perr  output  1  head-entry parity error.
REQ-014 rx_ferr  output  1  head-entry framing error.
REQ-015 rx_empty  output  1  FIFO holds no entries.
REQ-016 rx_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-017 overrun  output  1  sticky: a completed frame was dropped.

Function
REQ-018 rx passes through a 2-flop synchroniser; all sampling uses the synchronised value.
REQ-019 Tick generator: counter 0..divisor, one-cycle tick when count==divisor, then wrap to 0; divisor=0 gives tick every cycle.
REQ-020 divisor changes take effect at the next counter wrap; counter never exceeds the new value.
REQ-021 FSM states IDLE, START, DATA, PARITY, STOP; tick counter s (4 bits), bit counter n.
REQ-022 IDLE: on synchronised rx=0 clear s, go START; tick counter not required.
REQ-023 START: on tick with s==7, go DATA if rx=0 (clear s, n), else return to IDLE (glitch rejected, nothing pushed).
REQ-024 DATA: on tick with s==15 shift rx in LSB-first, clear s; after bit DBIT-1 go PARITY if parity enabled, else STOP.
REQ-025 PARITY: on tick with s==15 sample parity bit; perr=1 if XOR(data, bit) is 1 for even or 0 for odd; go STOP.
REQ-026 STOP: on tick with s==SB_TICK-1 sample rx; ferr=1 if rx=0; push {ferr, perr, data} to FIFO; go IDLE.
REQ-027 perr is 0 whenever parity disabled; parity_mode is sampled at START exit and held for the frame.
REQ-028 Push when full: frame dropped, FIFO unchanged, overrun set next cycle.
REQ-029 FIFO is first-word-fall-through; head outputs update the cycle after push into an empty FIFO.
REQ-030 rd_en while empty is ignored; no pointer change.
REQ-031 Push and pop same cycle while full: pop performed, push accepted, no overrun, stays full.
REQ-032 Push and pop same cycle while empty: push accepted, pop ignored.
REQ-033 Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
REQ-034 clr_err clears overrun next cycle; simultaneous clr_err and new overrun leaves overrun=1.

Reset
REQ-035 reset_n low asynchronously forces FSM IDLE, counters 0, synchroniser flops 1, FIFO empty.
REQ-036 During reset: rx_empty=1, rx_full=0, overrun=0, rx_data=0, rx_perr=0, rx_ferr=0.
REQ-037 Reset mid-frame discards the partial frame; after release receiver waits in IDLE for the next falling edge.

Structure
REQ-038 Shared package uart_pkg holds parity_mode encodings and the receiver FSM state type.
REQ-039 FIFO is sub-module uart_rx_ext_fifo, width DBIT+2, depth FIFO_DEPTH; the rest is inline.

Verification
REQ-040 divisor=0, parity none, send 0xA5 at 16 clk/bit -> one entry, rx_data=0xA5, perr=0, ferr=0.
REQ-041 parity even, send 0x07 with parity bit 0 -> rx_perr=1; same with bit 1 -> rx_perr=0; odd mode inverts both.
REQ-042 Stop bit driven 0 for 0x3C -> rx_data=0x3C, rx_ferr=1; 4-tick low glitch on idle line -> no entry.
REQ-043 FIFO_DEPTH=4, send 5 frames no reads -> rx_full=1, first 4 retained in order, overrun=1; clr_err -> overrun=0.
REQ-044 Full FIFO, rd_en asserted in the cycle the 5th frame pushes -> no overrun, entries 2..5 remain.
REQ-045 Assert reset_n=0 in DATA of frame 0x55, release, send 0x81 -> only 0x81 received.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: parity_mode encodings and receiver FSM state type shared by the UART receiver files.
package uart_pkg;
   localparam logic [1:0] PM_NONE = 2'b00;
   localparam logic [1:0] PM_EVEN = 2'b01;
   localparam logic [1:0] PM_ODD  = 2'b10;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_ext_fifo.sv
// uart_rx_ext_fifo: first-word-fall-through FIFO; a push while full is dropped unless a pop frees the slot.
module uart_rx_ext_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_wr,
   input  logic [W-1:0] i_wdata,
   input  logic         i_rd,
   output logic [W-1:0] o_rdata,
   output logic         o_empty,
   output logic         o_full,
   output logic         o_drop
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic          w_wr, w_rd;
   assign o_empty = r_cnt == '0;
   assign o_full  = r_cnt == (AW+1)'(DEPTH);
   assign w_rd    = i_rd & ~o_empty;
   assign w_wr    = i_wr & (~o_full | w_rd);
   assign o_drop  = i_wr & ~w_wr;
   assign o_rdata = o_empty ? '0 : r_mem[r_rp];
   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wp] <= i_wdata;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= r_wp + AW'(w_wr);
         r_rp  <= r_rp + AW'(w_rd);
         r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      end
endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: 16x oversampling UART receiver with runtime divisor, optional parity and a status-tagged receive FIFO.
module uart_rx_ext import uart_pkg::*; #(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int DIV_BITS   = 11,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                rx,
   input  logic [DIV_BITS-1:0] divisor,
   input  logic [1:0]          parity_mode,
   input  logic                rd_en,
   input  logic                clr_err,
   output logic [DBIT-1:0]     rx_data,
   output logic                rx_perr,
   output logic                rx_ferr,
   output logic                rx_empty,
   output logic                rx_full,
   output logic                overrun
);
   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int NW = $clog2(DBIT);
   logic [1:0]          r_sync;
   logic [DIV_BITS-1:0] r_tcnt, r_div;
   rx_state_t           r_state;
   logic [SW-1:0]       r_s;
   logic [NW-1:0]       r_n;
   logic [DBIT-1:0]     r_b;
   logic [1:0]          r_pm;
   logic                r_perr, r_ferr, r_push, r_ovr;
   logic                w_rx, w_tick, w_pen, w_drop;
   logic [DBIT+1:0]     w_rdata;
   assign w_rx   = r_sync[1];
   assign w_tick = r_tcnt == r_div;
   assign w_pen  = (r_pm == PM_EVEN) || (r_pm == PM_ODD);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_sync <= 2'b11;
         r_tcnt <= '0;
         r_div  <= '0;
         r_ovr  <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], rx};
         r_tcnt <= w_tick ? '0 : r_tcnt + DIV_BITS'(1);
         r_div  <= w_tick ? divisor : r_div;
         r_ovr  <= w_drop | (r_ovr & ~clr_err);
      end
   // s counts ticks within a bit; START samples at mid-bit (s==7), the rest at s==15
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state <= IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_b     <= '0;
         r_pm    <= PM_NONE;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_push  <= 1'b0;
      end else begin
         r_push <= 1'b0;
         case (r_state)
            IDLE:
               if (!w_rx) begin
                  r_s     <= '0;
                  r_state <= START;
               end
            START:
               if (w_tick) begin
                  if (r_s == SW'(7)) begin
                     r_state <= w_rx ? IDLE : DATA;
                     r_s     <= '0;
                     r_n     <= '0;
                     r_pm    <= parity_mode;
                     r_perr  <= 1'b0;
                  end else r_s <= r_s + SW'(1);
               end
            DATA:
               if (w_tick) begin
                  if (r_s == SW'(15)) begin
                     r_b <= {w_rx, r_b[DBIT-1:1]};
                     r_s <= '0;
                     r_n <= r_n + NW'(1);
                     if (r_n == NW'(DBIT-1)) r_state <= w_pen ? PARITY : STOP;
                  end else r_s <= r_s + SW'(1);
               end
            PARITY:
               if (w_tick) begin
                  if (r_s == SW'(15)) begin
                     r_perr  <= (^r_b) ^ w_rx ^ (r_pm == PM_ODD);
                     r_s     <= '0;
                     r_state <= STOP;
                  end else r_s <= r_s + SW'(1);
               end
            STOP:
               if (w_tick) begin
                  if (r_s == SW'(SB_TICK-1)) begin
                     r_ferr  <= ~w_rx;
                     r_push  <= 1'b1;
                     r_state <= IDLE;
                  end else r_s <= r_s + SW'(1);
               end
            default: r_state <= IDLE;
         endcase
      end
   uart_rx_ext_fifo #(.W(DBIT+2), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_wr    (r_push),
      .i_wdata ({r_ferr, r_perr, r_b}),
      .i_rd    (rd_en),
      .o_rdata (w_rdata),
      .o_empty (rx_empty),
      .o_full  (rx_full),
      .o_drop  (w_drop)
   );
   assign {rx_ferr, rx_perr, rx_data} = w_rdata;
   assign overrun = r_ovr;
endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: directed scenario tests for uart_rx_ext with a 4-entry FIFO.
module tb_uart_rx_ext;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx = 1'b1;
   logic [10:0] divisor = '0;
   logic [1:0]  parity_mode = 2'b00;
   logic        rd_en = 1'b0;
   logic        clr_err = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_perr, rx_ferr, rx_empty, rx_full, overrun;
   int          n_tests = 0;
   int          n_fail = 0;

   uart_rx_ext #(.FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rx          (rx),
      .divisor     (divisor),
      .parity_mode (parity_mode),
      .rd_en       (rd_en),
      .clr_err     (clr_err),
      .rx_data     (rx_data),
      .rx_perr     (rx_perr),
      .rx_ferr     (rx_ferr),
      .rx_empty    (rx_empty),
      .rx_full     (rx_full),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   task automatic send(input logic [7:0] d, input int pbit, input logic stop, input int per);
      rx = 1'b0;
      repeat (per) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (per) @(posedge clk);
         #1;
      end
      if (pbit >= 0) begin
         rx = pbit[0];
         repeat (per) @(posedge clk);
         #1;
      end
      rx = stop;
      repeat (per) @(posedge clk);
      #1;
      rx = 1'b1;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests += 6;
      if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", rx_empty); end
      if (rx_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", rx_full); end
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", rx_data); end
      if (rx_perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", rx_perr); end
      if (rx_ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", rx_ferr); end
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      parity_mode = 2'b00;
      send(8'hA5, -1, 1'b1, 16);
      n_tests += 5;
      if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL basic_empty got %b want 0", rx_empty); end
      if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h want a5", rx_data); end
      if (rx_perr !== 1'b0) begin n_fail++; $display("FAIL basic_perr got %b want 0", rx_perr); end
      if (rx_ferr !== 1'b0) begin n_fail++; $display("FAIL basic_ferr got %b want 0", rx_ferr); end
      pop();
      if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL basic_pop_empty got %b want 1", rx_empty); end
   endtask

   task automatic test_parity();
      logic [1:0] modes [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
      int         pbits [4] = '{0, 1, 0, 1};
      logic       exp   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         parity_mode = modes[i];
         send(8'h07, pbits[i], 1'b1, 16);
         n_tests += 3;
         if (rx_data !== 8'h07) begin n_fail++; $display("FAIL parity_data[%0d] got %h want 07", i, rx_data); end
         if (rx_perr !== exp[i]) begin n_fail++; $display("FAIL parity_perr[%0d] got %b want %b", i, rx_perr, exp[i]); end
         if (rx_ferr !== 1'b0) begin n_fail++; $display("FAIL parity_ferr[%0d] got %b want 0", i, rx_ferr); end
         pop();
      end
      parity_mode = 2'b00;
   endtask

   task automatic test_framing();
      send(8'h3C, -1, 1'b0, 16);
      repeat (20) @(posedge clk);
      #1;
      n_tests += 4;
      if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data got %h want 3c", rx_data); end
      if (rx_ferr !== 1'b1) begin n_fail++; $display("FAIL ferr_flag got %b want 1", rx_ferr); end
      pop();
      if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL ferr_single_entry got empty=%b want 1", rx_empty); end
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL glitch_empty got %b want 1", rx_empty); end
   endtask

   task automatic test_divisor();
      divisor = 11'd1;
      send(8'h5A, -1, 1'b1, 32);
      divisor = 11'd0;
      repeat (8) @(posedge clk);
      #1;
      n_tests += 2;
      if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL div_data got %h want 5a", rx_data); end
      if (rx_ferr !== 1'b0) begin n_fail++; $display("FAIL div_ferr got %b want 0", rx_ferr); end
      pop();
   endtask

   task automatic test_overrun();
      logic [7:0] d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 5; i++) send(d[i], -1, 1'b1, 16);
      n_tests += 2;
      if (rx_full !== 1'b1) begin n_fail++; $display("FAIL ovr_full got %b want 1", rx_full); end
      if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", overrun); end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (rx_data !== d[i]) begin n_fail++; $display("FAIL ovr_order[%0d] got %h want %h", i, rx_data, d[i]); end
         pop();
      end
      n_tests += 2;
      if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL ovr_drained got %b want 1", rx_empty); end
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", overrun); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d [5] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
      for (int i = 0; i < 4; i++) send(d[i], -1, 1'b1, 16);
      fork
         send(d[4], -1, 1'b1, 16);
         begin
            repeat (155) @(posedge clk);
            #1;
            rd_en = 1'b1;
            @(posedge clk);
            #1;
            rd_en = 1'b0;
         end
      join
      n_tests += 2;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b want 0", overrun); end
      if (rx_full !== 1'b1) begin n_fail++; $display("FAIL b2b_full got %b want 1", rx_full); end
      for (int i = 1; i < 5; i++) begin
         n_tests++;
         if (rx_data !== d[i]) begin n_fail++; $display("FAIL b2b_order[%0d] got %h want %h", i, rx_data, d[i]); end
         pop();
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d = 8'h55;
      rx = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         rx = d[i];
         repeat (16) @(posedge clk);
         #1;
      end
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx = 1'b1;
      reset_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      n_tests += 4;
      if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_discard got empty=%b want 1", rx_empty); end
      send(8'h81, -1, 1'b1, 16);
      if (rx_data !== 8'h81) begin n_fail++; $display("FAIL midrst_data got %h want 81", rx_data); end
      if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL midrst_entry got empty=%b want 0", rx_empty); end
      pop();
      if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_single got empty=%b want 1", rx_empty); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_divisor();
      test_overrun();
      test_back_to_back();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
